// File: rtl/data_break_arbiter_pkg.sv
// Shared types and constants for the data-break arbiter: break states, phases,
// CPU cycle-start encodings and the device one-hot helper.
package data_break_arbiter_pkg;

   localparam int NDEV   = 4;
   localparam int IDX_W  = 2;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 12;

   typedef enum logic [1:0] {
      BRK_IDLE = 2'd0,
      BRK_WC   = 2'd1,
      BRK_CA   = 2'd2,
      BRK_DT   = 2'd3
   } brk_state_e;

   localparam logic [1:0] PH_P0 = 2'd0;
   localparam logic [1:0] PH_P1 = 2'd1;
   localparam logic [1:0] PH_P2 = 2'd2;
   localparam logic [1:0] PH_P3 = 2'd3;

   // CPU major-cycle start states that may yield to a break.
   typedef enum logic [1:0] {
      CPU_F0 = 2'd0,
      CPU_D0 = 2'd1,
      CPU_E0 = 2'd2
   } cpu_state_e;

   function automatic logic [NDEV-1:0] dev_onehot(input logic [IDX_W-1:0] idx);
      logic [NDEV-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/data_break_arbiter_brk_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module brk_prio_enc
   import data_break_arbiter_pkg::*;
#(
   parameter int N  = NDEV,
   parameter int IW = IDX_W
) (
   input  logic [N-1:0]  req,
   output logic          valid,
   output logic [IW-1:0] idx
);

   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/data_break_arbiter.sv
// Data-break arbiter: yields core memory to DMA devices at CPU cycle starts,
// running single-cycle (DT) or three-cycle (WC, CA, DT) breaks of four phases each.
//   state    | meaning
//   BRK_IDLE | CPU owns memory; grant evaluated here
//   BRK_WC   | word-count read / increment / write-back
//   BRK_CA   | current-address read / increment / write-back
//   BRK_DT   | data transfer, then done pulse and return to idle
module data_break_arbiter
   import data_break_arbiter_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cpu_idle_slot,
   output logic                     cpu_hold,
   input  logic [NDEV-1:0]          brk_req,
   input  logic [NDEV-1:0]          brk_3cyc,
   input  logic [NDEV-1:0]          brk_dir,
   input  logic [NDEV*ADDR_W-1:0]   brk_addr,
   input  logic [NDEV*DATA_W-1:0]   brk_wdata,
   output logic [NDEV-1:0]          brk_grant,
   output logic [NDEV-1:0]          brk_done,
   output logic [NDEV-1:0]          brk_ovf,
   output logic [DATA_W-1:0]        brk_rdata,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic                     mem_read,
   output logic                     mem_write,
   input  logic [DATA_W-1:0]        mem_rdata
);

   brk_state_e          state_q, state_d;
   logic [1:0]          phase_q, phase_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                dir_q, dir_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ovf_q, ovf_d;
   logic                block_q, block_d;

   logic                enc_valid;
   logic [IDX_W-1:0]    enc_idx;
   logic                grant_ok;
   logic [DATA_W-1:0]   data_inc;
   logic [ADDR_W-1:0]   ca_addr;

   brk_prio_enc #(.N(NDEV), .IW(IDX_W)) u_prio (
      .req   (brk_req),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   assign grant_ok = (state_q == BRK_IDLE) && cpu_idle_slot && enc_valid && !block_q;
   assign data_inc = data_q + 12'd1;
   // CA sits right after WC and wraps inside its field.
   assign ca_addr  = {addr_q[ADDR_W-1:DATA_W], addr_q[DATA_W-1:0] + 12'd1};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BRK_IDLE;
         phase_q <= PH_P0;
         idx_q   <= '0;
         dir_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         ovf_q   <= 1'b0;
         block_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         dir_q   <= dir_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         ovf_q   <= ovf_d;
         block_q <= block_d;
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      dir_d   = dir_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      ovf_d   = ovf_q;
      block_d = block_q && cpu_idle_slot;
      if (state_q == BRK_IDLE) begin
         phase_d = PH_P0;
         if (grant_ok) begin
            idx_d   = enc_idx;
            dir_d   = brk_dir[enc_idx];
            addr_d  = brk_addr[int'(enc_idx)*ADDR_W +: ADDR_W];
            wdata_d = brk_wdata[int'(enc_idx)*DATA_W +: DATA_W];
            ovf_d   = 1'b0;
            state_d = brk_3cyc[enc_idx] ? BRK_WC : BRK_DT;
         end
      end else begin
         phase_d = phase_q + 2'd1;
         if (phase_q == PH_P1) begin
            if (state_q != BRK_DT) data_d = mem_rdata;
            else if (!dir_q)       rdata_d = mem_rdata;
         end
         if (state_q == BRK_WC && phase_q == PH_P2 && data_inc == '0) ovf_d = 1'b1;
         if (phase_q == PH_P3) begin
            case (state_q)
               BRK_WC: state_d = BRK_CA;
               BRK_CA: begin
                  state_d = BRK_DT;
                  addr_d  = {addr_q[ADDR_W-1:DATA_W], data_inc};
               end
               default: begin
                  state_d = BRK_IDLE;
                  block_d = 1'b1;
               end
            endcase
         end
      end
   end

   always_comb begin
      brk_grant = '0;
      brk_done  = '0;
      brk_ovf   = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if (state_q != BRK_IDLE) begin
         brk_grant = dev_onehot(idx_q);
         mem_addr  = (state_q == BRK_CA) ? ca_addr : addr_q;
         mem_read  = (phase_q == PH_P0) && (state_q != BRK_DT || !dir_q);
         mem_write = (phase_q == PH_P2) && (state_q != BRK_DT || dir_q);
         if (mem_write) mem_wdata = (state_q == BRK_DT) ? wdata_q : data_inc;
         if (state_q == BRK_DT && phase_q == PH_P3) begin
            brk_done = dev_onehot(idx_q);
            if (ovf_q) brk_ovf = dev_onehot(idx_q);
         end
      end
   end

   assign brk_rdata = rdata_q;
   assign cpu_hold  = (state_q != BRK_IDLE) || (cpu_idle_slot && enc_valid && !block_q);

endmodule

// File: tb/tb_data_break_arbiter.sv
// Scoreboard bench for data_break_arbiter with a behavioural core memory.
module tb_data_break_arbiter;

   localparam int NDEV = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic                cpu_idle_slot;
   logic                cpu_hold;
   logic [NDEV-1:0]     brk_req, brk_3cyc, brk_dir;
   logic [NDEV*15-1:0]  brk_addr;
   logic [NDEV*12-1:0]  brk_wdata;
   logic [NDEV-1:0]     brk_grant, brk_done, brk_ovf;
   logic [11:0]         brk_rdata;
   logic [14:0]         mem_addr;
   logic [11:0]         mem_wdata;
   logic                mem_read, mem_write;
   logic [11:0]         mem_rdata;

   logic [11:0]         mem [0:32767];
   logic                pl_en;
   logic [14:0]         pl_addr;
   logic [11:0]         pl_data;

   typedef struct {
      int          dev;
      logic        ovf;
      logic        chk_rd;
      logic [11:0] rd;
      int          hold;
      int          wrs;
      int          wpos;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_done   = 0;
   int   hold_run = 0;
   int   wr_cnt   = 0;
   int   wr_pos   = 0;

   always #5 clk = ~clk;

   data_break_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_idle_slot (cpu_idle_slot),
      .cpu_hold      (cpu_hold),
      .brk_req       (brk_req),
      .brk_3cyc      (brk_3cyc),
      .brk_dir       (brk_dir),
      .brk_addr      (brk_addr),
      .brk_wdata     (brk_wdata),
      .brk_grant     (brk_grant),
      .brk_done      (brk_done),
      .brk_ovf       (brk_ovf),
      .brk_rdata     (brk_rdata),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_rdata     (mem_rdata)
   );

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_write) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem_read ? mem[mem_addr] : 12'o0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0o expected %0o", tag, got, exp);
      end
   endtask

   function automatic logic [NDEV-1:0] oh(input int dev);
      logic [NDEV-1:0] v;
      v = '0;
      v[dev] = 1'b1;
      return v;
   endfunction

   // Completion monitor: pops the oldest expectation on each done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_run = 0;
            wr_cnt   = 0;
            wr_pos   = 0;
         end else begin
            hold_run = cpu_hold ? hold_run + 1 : 0;
            if (mem_write) begin
               wr_cnt++;
               wr_pos = hold_run;
            end
            if (|brk_done) begin
               if (sb.size() == 0) begin
                  check("unexpected_done", 32'(brk_done), 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("done_vec",  32'(brk_done),  32'(oh(e.dev)));
                  check("grant_vec", 32'(brk_grant), 32'(oh(e.dev)));
                  check("ovf_vec",   32'(brk_ovf),   e.ovf ? 32'(oh(e.dev)) : 32'd0);
                  if (e.chk_rd) check("rdata", 32'(brk_rdata), 32'(e.rd));
                  check("hold_cycles", hold_run, e.hold);
                  check("write_count", wr_cnt, e.wrs);
                  check("write_pos", wr_pos, e.wpos);
               end
               wr_cnt = 0;
               wr_pos = 0;
               n_done++;
            end
         end
      end
   end

   task automatic preload(input logic [14:0] a, input logic [11:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic set_dev(input int dev, input logic c3, input logic dir,
                          input logic [14:0] a, input logic [11:0] wd);
      brk_3cyc[dev]            = c3;
      brk_dir[dev]             = dir;
      brk_addr[dev*15 +: 15]   = a;
      brk_wdata[dev*12 +: 12]  = wd;
   endtask

   function automatic exp_t mk_exp(input int dev, input logic c3, input logic dir,
                                   input logic ovf, input logic [11:0] rd);
      exp_t e;
      e.dev    = dev;
      e.ovf    = ovf;
      e.chk_rd = !dir;
      e.rd     = rd;
      e.hold   = c3 ? 13 : 5;
      e.wrs    = (c3 ? 2 : 0) + (dir ? 1 : 0);
      e.wpos   = dir ? (c3 ? 12 : 4) : (c3 ? 8 : 0);
      return e;
   endfunction

   task automatic wait_done(input int target, input string tag);
      for (int k = 0; k < 60 && n_done < target; k++) @(posedge clk);
      check(tag, n_done, target);
   endtask

   task automatic cpu_gap();
      cpu_idle_slot = 1'b0;
      @(posedge clk);
      #1 cpu_idle_slot = 1'b1;
   endtask

   task automatic run_break(input int dev, input logic c3, input logic dir,
                            input logic [14:0] a, input logic [11:0] wd,
                            input logic ovf, input logic [11:0] rd);
      int target;
      set_dev(dev, c3, dir, a, wd);
      sb.push_back(mk_exp(dev, c3, dir, ovf, rd));
      target = n_done + 1;
      @(posedge clk);
      #1 brk_req[dev] = 1'b1;
      wait_done(target, "break_timeout");
      #1 brk_req[dev] = 1'b0;
      cpu_gap();
   endtask

   initial begin
      int target;
      reset         = 1'b1;
      cpu_idle_slot = 1'b1;
      brk_req       = '0;
      brk_3cyc      = '0;
      brk_dir       = '0;
      brk_addr      = '0;
      brk_wdata     = '0;
      pl_en         = 1'b0;
      pl_addr       = '0;
      pl_data       = '0;

      preload(15'o10300, 12'o4321);
      preload(15'o00500, 12'o0000);
      preload(15'o00010, 12'o7776);
      preload(15'o00011, 12'o0777);
      preload(15'o01000, 12'o5555);
      preload(15'o01001, 12'o2222);
      preload(15'o30020, 12'o0005);
      preload(15'o30021, 12'o7777);
      preload(15'o30000, 12'o6060);
      preload(15'o20100, 12'o0001);
      preload(15'o20101, 12'o0200);
      preload(15'o00600, 12'o1111);
      preload(15'o00700, 12'o3333);
      preload(15'o00040, 12'o0100);
      preload(15'o00041, 12'o0200);
      preload(15'o00201, 12'o4444);

      check("rst_hold",  32'(cpu_hold),  32'd0);
      check("rst_grant", 32'(brk_grant), 32'd0);
      check("rst_write", 32'(mem_write), 32'd0);
      check("rst_rdata", 32'(brk_rdata), 32'd0);
      check("rst_addr",  32'(mem_addr),  32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Single-cycle read and write.
      run_break(2, 1'b0, 1'b0, 15'o10300, 12'o0000, 1'b0, 12'o4321);
      run_break(1, 1'b0, 1'b1, 15'o00500, 12'o1234, 1'b0, 12'o0000);
      check("mem_0500", 32'(mem[15'o00500]), 32'o1234);

      // Three-cycle read, then repeated so WC overflows.
      run_break(0, 1'b1, 1'b0, 15'o00010, 12'o0000, 1'b0, 12'o5555);
      check("wc_first", 32'(mem[15'o00010]), 32'o7777);
      check("ca_first", 32'(mem[15'o00011]), 32'o1000);
      run_break(0, 1'b1, 1'b0, 15'o00010, 12'o0000, 1'b1, 12'o2222);
      check("wc_second", 32'(mem[15'o00010]), 32'o0000);
      check("ca_second", 32'(mem[15'o00011]), 32'o1001);

      // CA wraps inside field 3.
      run_break(2, 1'b1, 1'b0, 15'o30020, 12'o0000, 1'b0, 12'o6060);
      check("ca_wrap", 32'(mem[15'o30021]), 32'o0000);
      check("wc_wrap", 32'(mem[15'o30020]), 32'o0006);

      // Three-cycle write.
      run_break(3, 1'b1, 1'b1, 15'o20100, 12'o7070, 1'b0, 12'o0000);
      check("wr3_data", 32'(mem[15'o20201]), 32'o7070);
      check("wr3_wc",   32'(mem[15'o20100]), 32'o0002);

      // Simultaneous requests: device 0 first, device 3 only after a CPU gap.
      set_dev(0, 1'b0, 1'b0, 15'o00600, 12'o0000);
      set_dev(3, 1'b0, 1'b0, 15'o00700, 12'o0000);
      sb.push_back(mk_exp(0, 1'b0, 1'b0, 1'b0, 12'o1111));
      sb.push_back(mk_exp(3, 1'b0, 1'b0, 1'b0, 12'o3333));
      target = n_done + 1;
      @(posedge clk);
      #1 brk_req = 4'b1001;
      wait_done(target, "prio_first_timeout");
      #1 brk_req[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("blocked_grant", 32'(brk_grant), 32'd0);
         check("blocked_hold",  32'(cpu_hold),  32'd0);
      end
      @(posedge clk);
      #1 cpu_gap();
      wait_done(target + 1, "prio_second_timeout");
      #1 brk_req[3] = 1'b0;
      cpu_gap();

      // Reset during WC P2 kills the write at once.
      set_dev(0, 1'b1, 1'b0, 15'o00040, 12'o0000);
      @(posedge clk);
      #1 brk_req[0] = 1'b1;
      for (int k = 0; k < 20 && !mem_write; k++) @(negedge clk);
      check("wc_p2_write", 32'(mem_write), 32'd1);
      #2;
      reset   = 1'b1;
      brk_req = '0;
      #1;
      check("rst_mid_write", 32'(mem_write), 32'd0);
      check("rst_mid_read",  32'(mem_read),  32'd0);
      check("rst_mid_addr",  32'(mem_addr),  32'd0);
      check("rst_mid_grant", 32'(brk_grant), 32'd0);
      check("rst_mid_hold",  32'(cpu_hold),  32'd0);
      check("rst_mid_rdata", 32'(brk_rdata), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      check("wc_untouched", 32'(mem[15'o00040]), 32'o0100);

      // A fresh request after reset proceeds normally.
      run_break(1, 1'b0, 1'b0, 15'o00201, 12'o0000, 1'b0, 12'o4444);
      check("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
